// File: rtl/ub_pkg.sv
// rtl/ub_pkg.sv - shared types and constants for the unified-buffer arbiter
package ub_pkg;
  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    REQ_FIFO = 2'd0,
    REQ_CMP  = 2'd1,
    REQ_ST   = 2'd2
  } req_id_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;
endpackage

// File: rtl/ub_arbiter_rr.sv
// rtl/ub_arbiter_rr.sv - round-robin picker with registered priority pointer
// The pointer names the highest-priority index; it moves past the winner on advance.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_winner,
  output logic [PW-1:0] o_next_ptr
);
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx [N];
  logic          w_found;

  always_comb begin
    o_winner   = '0;
    o_next_ptr = r_ptr;
    w_found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_idx[k] = PW'((int'(r_ptr) + k) % N);
      if (!w_found && i_req[w_idx[k]]) begin
        w_found              = 1'b1;
        o_winner[w_idx[k]]   = 1'b1;
        o_next_ptr           = PW'((int'(w_idx[k]) + 1) % N);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_advance && |i_req) begin
      r_ptr <= o_next_ptr;
    end
  end
endmodule

// File: rtl/ub_arbiter.sv
// rtl/ub_arbiter.sv - single-owner scheduler for the unified buffer
// Grants one of FIFO / compute / store, then drives ISSUE/WAIT beats until done.
module ub_arbiter
  import ub_pkg::*;
#(
  parameter int BUFFER_SIZE        = 1024,
  parameter int ADDRESS_SIZE       = $clog2(BUFFER_SIZE),
  parameter int BUFFER_WORD_SIZE   = 16,
  parameter int COMPUTE_DATA_WIDTH = 4,
  parameter int NUM_COMPUTE_LANES  = 64,
  parameter int ADDR_STRIDE        = NUM_COMPUTE_LANES * COMPUTE_DATA_WIDTH / BUFFER_WORD_SIZE,
  parameter int MAX_BURST          = 64,
  parameter int LEN_W              = $clog2(MAX_BURST + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_fifo_req,
  input  logic                    i_fifo_wr,
  input  logic                    i_fifo_section,
  input  logic [ADDRESS_SIZE-1:0] i_fifo_addr,
  input  logic                    i_cmp_req,
  input  logic                    i_cmp_wr,
  input  logic [ADDRESS_SIZE-1:0] i_cmp_addr,
  input  logic [LEN_W-1:0]        i_cmp_len,
  input  logic                    i_st_req,
  input  logic                    i_st_wr,
  input  logic [ADDRESS_SIZE-1:0] i_st_addr,
  output logic [NUM_REQ-1:0]      o_gnt,
  output logic [NUM_REQ-1:0]      o_rsp_valid,
  output logic                    o_busy,
  output logic                    o_ub_we,
  output logic                    o_ub_re,
  output logic                    o_ub_compute_en,
  output logic                    o_ub_fifo_en,
  output logic                    o_ub_store_en,
  output logic                    o_ub_section,
  output logic [ADDRESS_SIZE-1:0] o_ub_address,
  input  logic                    i_ub_done,
  output logic                    o_proto_err
);
  localparam int PW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      w_req;
  logic [NUM_REQ-1:0]      w_winner;
  logic [PW-1:0]           w_next_ptr;
  logic                    w_advance;
  req_id_e                 w_owner;
  logic                    w_sel_wr;
  logic                    w_sel_section;
  logic [ADDRESS_SIZE-1:0] w_sel_addr;
  logic [LEN_W-1:0]        w_sel_beats;
  logic [LEN_W-1:0]        w_cmp_beats;
  logic [ADDRESS_SIZE-1:0] w_next_addr;

  state_e                  r_state;
  req_id_e                 r_owner;
  logic                    r_wr;
  logic                    r_section;
  logic [ADDRESS_SIZE-1:0] r_addr;
  logic [LEN_W-1:0]        r_beats;

  assign w_req       = {i_st_req, i_cmp_req, i_fifo_req};
  assign w_advance   = (r_state == IDLE);
  // The winner always sits just behind the pointer it produces.
  assign w_owner     = req_id_e'((w_next_ptr == '0) ? PW'(NUM_REQ - 1) : w_next_ptr - PW'(1));
  assign w_next_addr = r_addr + ADDRESS_SIZE'(ADDR_STRIDE);
  assign o_busy      = (r_state != IDLE);
  assign o_rsp_valid = ((r_state == WAIT) && i_ub_done && !i_rst) ?
                       (NUM_REQ'(1) << r_owner) : '0;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (w_req),
    .i_advance  (w_advance),
    .o_winner   (w_winner),
    .o_next_ptr (w_next_ptr)
  );

  always_comb begin
    w_cmp_beats = i_cmp_len;
    if (i_cmp_len == '0) begin
      w_cmp_beats = LEN_W'(1);
    end else if (i_cmp_len > LEN_W'(MAX_BURST)) begin
      w_cmp_beats = LEN_W'(MAX_BURST);
    end
  end

  always_comb begin
    w_sel_wr      = i_fifo_wr;
    w_sel_section = i_fifo_section;
    w_sel_addr    = i_fifo_addr;
    w_sel_beats   = LEN_W'(1);
    case (w_owner)
      REQ_CMP: begin
        w_sel_wr      = i_cmp_wr;
        w_sel_section = 1'b0;
        w_sel_addr    = i_cmp_addr;
        w_sel_beats   = w_cmp_beats;
      end
      REQ_ST: begin
        w_sel_wr      = i_st_wr;
        w_sel_section = 1'b0;
        w_sel_addr    = i_st_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= IDLE;
      r_owner         <= REQ_FIFO;
      r_wr            <= 1'b0;
      r_section       <= 1'b0;
      r_addr          <= '0;
      r_beats         <= '0;
      o_gnt           <= '0;
      o_ub_we         <= 1'b0;
      o_ub_re         <= 1'b0;
      o_ub_compute_en <= 1'b0;
      o_ub_fifo_en    <= 1'b0;
      o_ub_store_en   <= 1'b0;
      o_ub_section    <= 1'b0;
      o_ub_address    <= '0;
      o_proto_err     <= 1'b0;
    end else begin
      // Buffer controls are one-cycle pulses; only ISSUE entry raises them.
      o_gnt           <= '0;
      o_ub_we         <= 1'b0;
      o_ub_re         <= 1'b0;
      o_ub_compute_en <= 1'b0;
      o_ub_fifo_en    <= 1'b0;
      o_ub_store_en   <= 1'b0;
      o_ub_section    <= 1'b0;
      o_ub_address    <= '0;
      if (i_ub_done && (r_state != WAIT)) begin
        o_proto_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_owner         <= w_owner;
            r_wr            <= w_sel_wr;
            r_section       <= w_sel_section;
            r_addr          <= w_sel_addr;
            r_beats         <= w_sel_beats;
            o_gnt           <= w_winner;
            o_ub_we         <= w_sel_wr;
            o_ub_re         <= !w_sel_wr;
            o_ub_fifo_en    <= (w_owner == REQ_FIFO);
            o_ub_compute_en <= (w_owner == REQ_CMP);
            o_ub_store_en   <= (w_owner == REQ_ST);
            o_ub_section    <= w_sel_section;
            o_ub_address    <= w_sel_addr;
            r_state         <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (i_ub_done) begin
            if (r_beats > LEN_W'(1)) begin
              r_beats         <= r_beats - LEN_W'(1);
              r_addr          <= w_next_addr;
              o_ub_we         <= r_wr;
              o_ub_re         <= !r_wr;
              o_ub_fifo_en    <= (r_owner == REQ_FIFO);
              o_ub_compute_en <= (r_owner == REQ_CMP);
              o_ub_store_en   <= (r_owner == REQ_ST);
              o_ub_section    <= (r_owner == REQ_FIFO) && r_section;
              o_ub_address    <= w_next_addr;
              r_state         <= ISSUE;
            end else begin
              r_beats <= '0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ub_arbiter.sv
// tb/tb_ub_arbiter.sv - self-checking bench for ub_arbiter
// Directed vector table, corner sequences, and a transaction-timeline reference model.
module tb_ub_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_req, fifo_wr, fifo_section;
  logic [9:0] fifo_addr;
  logic       cmp_req, cmp_wr;
  logic [9:0] cmp_addr;
  logic [6:0] cmp_len;
  logic       st_req, st_wr;
  logic [9:0] st_addr;
  logic       ub_done;
  logic [2:0] o_gnt, o_rsp_valid;
  logic       o_busy, o_ub_we, o_ub_re, o_ub_compute_en, o_ub_fifo_en, o_ub_store_en, o_ub_section;
  logic [9:0] o_ub_address;
  logic       o_proto_err;

  logic auto_done = 1'b1;
  logic man_done  = 1'b0;
  logic done_pipe = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Buffer stand-in: done follows a we/re pulse by one cycle.
  always @(posedge clk) done_pipe <= o_ub_we | o_ub_re;
  assign ub_done = auto_done ? done_pipe : man_done;

  ub_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_fifo_req(fifo_req), .i_fifo_wr(fifo_wr), .i_fifo_section(fifo_section), .i_fifo_addr(fifo_addr),
    .i_cmp_req(cmp_req), .i_cmp_wr(cmp_wr), .i_cmp_addr(cmp_addr), .i_cmp_len(cmp_len),
    .i_st_req(st_req), .i_st_wr(st_wr), .i_st_addr(st_addr),
    .o_gnt(o_gnt), .o_rsp_valid(o_rsp_valid), .o_busy(o_busy),
    .o_ub_we(o_ub_we), .o_ub_re(o_ub_re), .o_ub_compute_en(o_ub_compute_en),
    .o_ub_fifo_en(o_ub_fifo_en), .o_ub_store_en(o_ub_store_en), .o_ub_section(o_ub_section),
    .o_ub_address(o_ub_address), .i_ub_done(ub_done), .o_proto_err(o_proto_err)
  );

  typedef struct {
    int         id;
    bit         wr;
    bit         sec;
    int         addr;
    int         len;
    logic [2:0] e_gnt;
    int         e_beats;
    int         e_first;
    int         e_last;
    int         e_end;
    bit         e_sec;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] obs();
    return {o_gnt, o_rsp_valid, o_busy, o_ub_we, o_ub_re, o_ub_compute_en, o_ub_fifo_en,
            o_ub_store_en, o_ub_section, o_ub_address, o_proto_err};
  endfunction

  function automatic logic [23:0] mk(input logic [2:0] g, input logic [2:0] r, input logic b,
                                     input logic we, input logic re, input logic ce, input logic fe,
                                     input logic se, input logic sc, input int a, input logic pe);
    return {g, r, b, we, re, ce, fe, se, sc, 10'(a), pe};
  endfunction

  task automatic set_req(input int id, input bit req, input bit wr, input bit sec,
                         input int addr, input int len);
    case (id)
      0: begin fifo_req = req; fifo_wr = wr; fifo_section = sec; fifo_addr = 10'(addr); end
      1: begin cmp_req = req; cmp_wr = wr; cmp_addr = 10'(addr); cmp_len = 7'(len); end
      default: begin st_req = req; st_wr = wr; st_addr = 10'(addr); end
    endcase
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    for (int r = 0; r < 3; r++) set_req(r, 1'b0, 1'b0, 1'b0, 0, 0);
    man_done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (o_busy && c < 300) begin
      step();
      c++;
    end
    if (o_busy) check("idle_timeout", 1, 0);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int gcnt, icnt, rcnt, first, last, endc;
    logic [2:0] gval;
    bit bad;
    gcnt = 0; icnt = 0; rcnt = 0; first = -1; last = -1; endc = -1; gval = '0; bad = 1'b0;
    set_req(v.id, 1'b1, v.wr, v.sec, v.addr, v.len);
    for (int c = 1; c <= 200; c++) begin
      step();
      if (o_gnt != 3'b000) begin
        gcnt++;
        gval = o_gnt;
        set_req(v.id, 1'b0, v.wr, v.sec, v.addr, v.len);
      end
      if (o_ub_we || o_ub_re) begin
        icnt++;
        if (first < 0) first = int'(o_ub_address);
        last = int'(o_ub_address);
        if ({o_ub_store_en, o_ub_compute_en, o_ub_fifo_en} != v.e_gnt || o_ub_we != v.wr ||
            o_ub_re == v.wr || o_ub_section != v.e_sec)
          bad = 1'b1;
      end
      if (o_rsp_valid != 3'b000) begin
        rcnt++;
        if (o_rsp_valid != v.e_gnt) bad = 1'b1;
      end
      if (!o_busy) begin
        endc = c;
        break;
      end
    end
    check($sformatf("vec%0d gnt", n), 64'(gval), 64'(v.e_gnt));
    check($sformatf("vec%0d gnt_count", n), 64'(gcnt), 64'(1));
    check($sformatf("vec%0d beats", n), 64'(icnt), 64'(v.e_beats));
    check($sformatf("vec%0d rsp_count", n), 64'(rcnt), 64'(v.e_beats));
    check($sformatf("vec%0d first_addr", n), 64'(first), 64'(v.e_first));
    check($sformatf("vec%0d last_addr", n), 64'(last), 64'(v.e_last));
    check($sformatf("vec%0d idle_cycle", n), 64'(endc), 64'(v.e_end));
    check($sformatf("vec%0d controls", n), 64'(bad), 64'(0));
    step();
  endtask

  // Random-phase model and requester state.
  bit  p_pend [3];
  bit  p_wr   [3];
  bit  p_sec  [3];
  int  p_addr [3];
  int  p_len  [3];
  bit  m_act, m_wr, m_sec;
  int  m_s, m_b, m_own, m_a, m_ptr, last_gnt, win, off, idx;
  logic [2:0] e_g, e_r, oh;
  logic e_we, e_re, e_ce, e_fe, e_se, e_sc;
  int  e_a;
  logic [2:0] got [4];
  int  gn;
  bit  bad;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //           id wr sec addr  len  gnt    beats first last end sec
    vecs[0]  = '{0, 1, 1,    5,   0, 3'b001,  1,    5,    5,   3, 1};
    vecs[1]  = '{1, 0, 0,   32,   3, 3'b010,  3,   32,   64,   7, 0};
    vecs[2]  = '{1, 0, 0, 1008,   2, 3'b010,  2, 1008,    0,   5, 0};
    vecs[3]  = '{1, 1, 0,  100,   0, 3'b010,  1,  100,  100,   3, 0};
    vecs[4]  = '{1, 0, 0,    0, 100, 3'b010, 64,    0, 1008, 129, 0};
    vecs[5]  = '{2, 1, 0,    7,   0, 3'b100,  1,    7,    7,   3, 0};
    vecs[6]  = '{2, 0, 0, 1023,   5, 3'b100,  1, 1023, 1023,   3, 0};
    vecs[7]  = '{0, 0, 0, 1023,   0, 3'b001,  1, 1023, 1023,   3, 0};
    vecs[8]  = '{1, 1, 0, 1020,   2, 3'b010,  2, 1020,   12,   5, 0};
    vecs[9]  = '{1, 0, 0,   16,  64, 3'b010, 64,   16,    0, 129, 0};
    vecs[10] = '{0, 1, 0,  300,   0, 3'b001,  1,  300,  300,   3, 0};

    reset_dut();
    check("reset_state", 64'(obs()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));

    for (int n = 0; n < 11; n++) run_vec(n, vecs[n]);

    // Fairness: all three held high from reset.
    reset_dut();
    for (int r = 0; r < 3; r++) set_req(r, 1'b1, 1'b0, 1'b0, 40 + r, 1);
    gn = 0;
    for (int i = 0; i < 4; i++) got[i] = '0;
    for (int c = 0; c < 100 && gn < 4; c++) begin
      step();
      if (o_gnt != 3'b000) begin
        got[gn] = o_gnt;
        gn++;
      end
    end
    check("rr_grant0", 64'(got[0]), 64'(3'b001));
    check("rr_grant1", 64'(got[1]), 64'(3'b010));
    check("rr_grant2", 64'(got[2]), 64'(3'b100));
    check("rr_grant3", 64'(got[3]), 64'(3'b001));
    for (int r = 0; r < 3; r++) set_req(r, 1'b0, 1'b0, 1'b0, 0, 0);
    wait_idle();

    // Hold in WAIT indefinitely without done.
    reset_dut();
    auto_done = 1'b0;
    set_req(2, 1'b1, 1'b0, 1'b0, 77, 0);
    step();
    check("hold_issue", 64'(obs()), 64'(mk(3'b100, 0, 1, 0, 1, 0, 0, 1, 0, 77, 0)));
    set_req(2, 1'b0, 1'b0, 1'b0, 77, 0);
    bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (obs() != mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)) bad = 1'b1;
    end
    check("hold_wait", 64'(bad), 64'(0));
    man_done = 1'b1;
    #1;
    check("hold_rsp", 64'(obs()), 64'(mk(0, 3'b100, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    step();
    man_done = 1'b0;
    check("hold_idle", 64'(obs()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));

    // Reset during WAIT of the second beat of a 4-beat burst, then a stray done.
    reset_dut();
    set_req(1, 1'b1, 1'b0, 1'b0, 200, 4);
    step();
    set_req(1, 1'b0, 1'b0, 1'b0, 200, 4);
    step();
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    check("burst_beat2", 64'(obs()), 64'(mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 216, 0)));
    step();
    rst = 1'b1;
    man_done = 1'b1;
    #1;
    check("rst_no_rsp", 64'(o_rsp_valid), 64'(0));
    step();
    rst = 1'b0;
    man_done = 1'b0;
    check("after_rst", 64'(obs()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    check("stray_done", 64'(obs()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
    step(); step(); step();
    check("proto_sticky", 64'(o_proto_err), 64'(1));
    reset_dut();
    check("proto_cleared", 64'(o_proto_err), 64'(0));
    auto_done = 1'b1;

    // Randomized traffic against a transaction-timeline model.
    reset_dut();
    m_act = 1'b0; m_ptr = 0; last_gnt = -1;
    m_s = 0; m_b = 0; m_own = 0; m_a = 0; m_wr = 1'b0; m_sec = 1'b0;
    for (int r = 0; r < 3; r++) begin
      p_pend[r] = 1'b0; p_wr[r] = 1'b0; p_sec[r] = 1'b0; p_addr[r] = 0; p_len[r] = 0;
    end
    for (int q = 0; q < 1500; q++) begin
      if (m_act && q >= m_s + 2 * m_b) m_act = 1'b0;
      e_g = '0; e_r = '0; e_we = 0; e_re = 0; e_ce = 0; e_fe = 0; e_se = 0; e_sc = 0; e_a = 0;
      oh = 3'(1 << m_own);
      if (m_act) begin
        off = q - m_s;
        if (off % 2 == 0) begin
          e_a  = (m_a + 16 * (off / 2)) % 1024;
          e_we = m_wr;
          e_re = !m_wr;
          e_fe = (m_own == 0);
          e_ce = (m_own == 1);
          e_se = (m_own == 2);
          e_sc = (m_own == 0) && m_sec;
          if (off == 0) e_g = oh;
        end else begin
          e_r = oh;
        end
      end
      check($sformatf("rand q=%0d", q), 64'(obs()),
            64'(mk(e_g, e_r, m_act, e_we, e_re, e_ce, e_fe, e_se, e_sc, e_a, 0)));

      if (last_gnt >= 0) begin
        p_pend[last_gnt] = 1'b0;
        last_gnt = -1;
      end
      for (int r = 0; r < 3; r++) begin
        if (!p_pend[r]) begin
          if ($urandom_range(0, 3) == 0) begin
            p_pend[r] = 1'b1;
            p_wr[r]   = 1'($urandom_range(0, 1));
            p_sec[r]  = 1'($urandom_range(0, 1));
            p_addr[r] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1000, 1023))
                                                     : int'($urandom_range(0, 1023));
            p_len[r]  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 127))
                                                     : int'($urandom_range(0, 5));
          end
        end else if ($urandom_range(0, 31) == 0) begin
          p_pend[r] = 1'b0;
        end
        set_req(r, p_pend[r], p_wr[r], p_sec[r], p_addr[r], p_len[r]);
      end

      if (!m_act && (p_pend[0] || p_pend[1] || p_pend[2])) begin
        win = -1;
        for (int j = 0; j < 3; j++) begin
          idx = (m_ptr + j) % 3;
          if (win < 0 && p_pend[idx]) win = idx;
        end
        m_own = win;
        m_wr  = p_wr[win];
        m_sec = p_sec[win];
        m_a   = p_addr[win];
        if (win == 1) m_b = (p_len[1] == 0) ? 1 : ((p_len[1] > 64) ? 64 : p_len[1]);
        else          m_b = 1;
        m_s      = q + 1;
        m_act    = 1'b1;
        m_ptr    = (win + 1) % 3;
        last_gnt = win;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ub_arbiter.md
Name: ub_arbiter

Overview:
Single-owner scheduler for the unified buffer. It shares the buffer between three requesters: host FIFO byte port (REQ 0), compute array vector port (REQ 1) and accumulator store port (REQ 2). It drives the buffer's we/re/enable/section/address controls and consumes its done strobe. Compute requests may be multi-beat bursts that auto-increment the address by one vector stride. Data buses connect requesters to the buffer directly; this block carries control only.

Parameters:
BUFFER_SIZE, 1024, words in buffer
ADDRESS_SIZE, $clog2(BUFFER_SIZE), buffer address width
BUFFER_WORD_SIZE, 16, bits per buffer word
COMPUTE_DATA_WIDTH, 4, bits per compute lane
NUM_COMPUTE_LANES, 64, compute lanes per vector
ADDR_STRIDE, NUM_COMPUTE_LANES*COMPUTE_DATA_WIDTH/BUFFER_WORD_SIZE (16), address step per compute beat
MAX_BURST, 64, max compute beats per grant
LEN_W, $clog2(MAX_BURST+1), burst length width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fifo_req / fifo_wr  in  1 / 1  FIFO access request / 1=write 0=read
fifo_section  in  1  byte select: 0 low, 1 high
fifo_addr  in  ADDRESS_SIZE  FIFO word address
cmp_req / cmp_wr  in  1 / 1  compute request / direction
cmp_addr  in  ADDRESS_SIZE  burst start address
cmp_len  in  LEN_W  beats; 0 treated as 1; values >MAX_BURST clamp to MAX_BURST
st_req / st_wr  in  1 / 1  store request / direction
st_addr  in  ADDRESS_SIZE  store word address
gnt  out  3  one-hot grant pulse, bit = requester index
rsp_valid  out  3  one-hot per-beat completion; buffer read data valid this cycle
busy  out  1  high whenever state != IDLE
ub_we, ub_re, ub_compute_en, ub_fifo_en, ub_store_en, ub_section  out  1 each  buffer controls
ub_address  out  ADDRESS_SIZE  buffer address
ub_done  in  1  buffer done strobe
proto_err  out  1  sticky: ub_done seen outside WAIT

Behaviour:
- Reset: state IDLE, RR pointer=0, beat counter=0, all outputs 0 including proto_err. Reset mid-burst aborts immediately; no rsp_valid is issued for the in-flight beat.
- The buffer has 1-cycle latency: ub_done goes high the cycle after we/re.
- FSM IDLE -> ISSUE -> WAIT.
- IDLE: if any req is high, pick a winner by round-robin. Latch owner, wr, addr, section and beats, then go to ISSUE. No request: stay in IDLE.
- Round-robin order: pointer is the highest-priority index. After a grant to i, pointer = (i+1) mod 3.
- ISSUE, exactly 1 cycle:
  - Drive ub_we=wr and ub_re=!wr.
  - Exactly one enable is high, matching owner. ub_section is driven only for the FIFO owner, else 0.
  - ub_address is the current beat address.
  - gnt[owner] pulses in the first ISSUE of a grant only.
  - Go to WAIT.
- WAIT: all ub_* controls are 0.
  - On ub_done: rsp_valid[owner]=1 that cycle (combinational from ub_done & WAIT).
  - If beats remain, address += ADDR_STRIDE modulo 2^ADDRESS_SIZE and go to ISSUE. Otherwise go to IDLE.
  - Without ub_done, hold in WAIT indefinitely.
- Cost: 3 cycles for a single access; 2 cycles per additional burst beat. No new arbitration happens during a burst (no preemption).
- Requester rule: req, addr and len are held until gnt; req is deasserted by the edge after gnt. A req still high when the FSM returns to IDLE is a new request.
- Simultaneous requests are resolved only by the pointer. A requester dropping req in IDLE before a grant is legal; nothing is latched.
- Address wrap: 1020+16 -> 12 for ADDRESS_SIZE=10. No bank-boundary checking; the buffer handles row rollover itself.
- ub_done while in IDLE or ISSUE sets proto_err (sticky until rst) and is otherwise ignored.

Decomposition:
- ub_pkg holds:
  - typedef enum req_id_e {REQ_FIFO=0, REQ_CMP=1, REQ_ST=2}
  - typedef enum state_e {IDLE, ISSUE, WAIT}
  - localparam NUM_REQ=3
- Sub-module rr_arbiter #(N=3): takes req vector, pointer and an advance strobe; returns a one-hot winner and the next pointer. It is purely combinational plus a pointer register with synchronous reset.

Test Plan:
- Single FIFO write: fifo_req=1, wr=1, section=1, addr=5.
  -> gnt=001 at cycle 1; ub_we=1, ub_fifo_en=1, ub_section=1, ub_address=5 at cycle 1; rsp_valid=001 at cycle 2; busy back to 0 at cycle 3.
- Compute read burst: cmp_addr=32, cmp_len=3.
  -> ub_re+ub_compute_en pulses at addresses 32, 48, 64 spaced 2 cycles apart; three rsp_valid=010 pulses; one gnt.
- Burst wrap: cmp_addr=1008, cmp_len=2 -> addresses 1008 then 0.
- All three req held high from reset -> grant order FIFO, CMP, ST, FIFO (round-robin fairness).
- Reset asserted in WAIT of beat 2 of a 4-beat burst -> next cycle all outputs 0 and state IDLE. The later stray ub_done sets proto_err=1.
- cmp_len=0 -> exactly one beat. cmp_len=100 -> exactly 64 beats.
